// File: rtl/feed_sequencer_pkg.sv
// Shared types and constants for the pet-feeder dispense sequencer.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    SETTLE   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic SRC_AUTO   = 1'b0;
  localparam logic SRC_MANUAL = 1'b1;

  localparam int unsigned FEED_CNT_W = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/feed_sequencer_if.sv
// Request/status bundle between the button debouncers, the sequencer and the motor driver.
interface feed_sequencer_if #(
  parameter int unsigned PORTION_W = 3
) ();
  import feeder_pkg::*;

  logic                  manual_req;
  logic                  portion_inc;
  logic                  auto_en;
  logic                  abort;
  logic                  motor_en;
  logic                  busy;
  logic                  feed_done;
  logic                  last_src_manual;
  logic [PORTION_W-1:0]  portions_sel;
  logic [FEED_CNT_W-1:0] feed_count;

  modport master (
    output manual_req, portion_inc, auto_en, abort,
    input  motor_en, busy, feed_done, last_src_manual, portions_sel, feed_count
  );

  modport slave (
    input  manual_req, portion_inc, auto_en, abort,
    output motor_en, busy, feed_done, last_src_manual, portions_sel, feed_count
  );

endinterface

// File: rtl/feed_sequencer_interval_timer.sv
// Free-running auto-feed period counter; wrap_c pulses on the last count of each period.
module feed_interval_timer #(
  parameter int unsigned INTERVAL_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic auto_en,
  output logic wrap_c
);

  localparam int unsigned CNT_W = $clog2(INTERVAL_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INTERVAL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign wrap_c = auto_en && (cnt == LAST);

  // Held at zero while disabled so re-enabling always starts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!auto_en || wrap_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/feed_sequencer.sv
// Pet-feeder dispense sequencer: arbitrates manual/auto requests, runs portions, enforces cooldown.
// Optional completed-feed counter enabled with `define FEED_COUNTER_EN.
module feed_sequencer
  import feeder_pkg::*;
#(
  parameter int unsigned DISPENSE_CYCLES = 50,
  parameter int unsigned SETTLE_CYCLES   = 20,
  parameter int unsigned COOLDOWN_CYCLES = 200,
  parameter int unsigned INTERVAL_CYCLES = 1000,
  parameter int unsigned MAX_PORTIONS    = 4,
  parameter int unsigned PORTION_W       = 3
) (
  input logic              clk,
  input logic              rst_n,
  feed_sequencer_if.slave  bus
);

  localparam int unsigned PH_MAX = max3(DISPENSE_CYCLES, SETTLE_CYCLES, COOLDOWN_CYCLES);
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_t               state, state_nxt;
  logic [PH_W-1:0]      phase, ph_load;
  logic [PORTION_W-1:0] remaining, sel_q;
  logic                 auto_pend, man_pend, wrap_c;
  logic                 expire, req, start, more, done_c, abort_c;
  logic                 motor_nxt, busy_nxt;
  logic                 motor_q, busy_q, done_q, src_q;

  feed_interval_timer #(
    .INTERVAL_CYCLES(INTERVAL_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .auto_en(bus.auto_en),
    .wrap_c (wrap_c)
  );

  assign expire = (phase == '0);
  assign req    = bus.manual_req | man_pend | auto_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort outranks phase expiry in the motor phases.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    more      = 1'b0;
    done_c    = 1'b0;
    abort_c   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          start     = 1'b1;
          state_nxt = DISPENSE;
        end
      end
      DISPENSE: begin
        if (bus.abort) begin
          abort_c   = 1'b1;
          state_nxt = COOLDOWN;
        end else if (expire) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          abort_c   = 1'b1;
          state_nxt = COOLDOWN;
        end else if (expire) begin
          if (remaining > PORTION_W'(1)) begin
            more      = 1'b1;
            state_nxt = DISPENSE;
          end else begin
            done_c    = 1'b1;
            state_nxt = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        if (expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    motor_nxt = (state_nxt == DISPENSE);
    busy_nxt  = (state_nxt != IDLE);
    ph_load   = '0;
    case (state_nxt)
      DISPENSE: ph_load = PH_W'(DISPENSE_CYCLES - 1);
      SETTLE:   ph_load = PH_W'(SETTLE_CYCLES - 1);
      COOLDOWN: ph_load = PH_W'(COOLDOWN_CYCLES - 1);
      default:  ph_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= '0;
      remaining <= '0;
      sel_q     <= PORTION_W'(1);
      auto_pend <= 1'b0;
      man_pend  <= 1'b0;
      motor_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      src_q     <= SRC_AUTO;
    end else begin
      if (state_nxt != state) begin
        phase <= ph_load;
      end else if (!expire) begin
        phase <= phase - PH_W'(1);
      end

      if (start) begin
        remaining <= sel_q;
      end else if (more) begin
        remaining <= remaining - PORTION_W'(1);
      end

      if (bus.portion_inc) begin
        sel_q <= (sel_q == PORTION_W'(MAX_PORTIONS)) ? PORTION_W'(1) : sel_q + PORTION_W'(1);
      end

      // Only a press landing on the final cooldown cycle is carried into IDLE.
      man_pend <= (state == COOLDOWN) && expire && bus.manual_req;

      if (!bus.auto_en || start || abort_c) begin
        auto_pend <= 1'b0;
      end else if (wrap_c) begin
        auto_pend <= 1'b1;
      end

      if (start) begin
        src_q <= (bus.manual_req | man_pend) ? SRC_MANUAL : SRC_AUTO;
      end

      motor_q <= motor_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_c;
    end
  end

  assign bus.motor_en        = motor_q;
  assign bus.busy            = busy_q;
  assign bus.feed_done       = done_q;
  assign bus.last_src_manual = src_q;
  assign bus.portions_sel    = sel_q;

`ifdef FEED_COUNTER_EN
  logic [FEED_CNT_W-1:0] feed_cnt_q;

  // Counts in step with feed_done and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feed_cnt_q <= '0;
    end else if (done_c && (feed_cnt_q != '1)) begin
      feed_cnt_q <= feed_cnt_q + FEED_CNT_W'(1);
    end
  end

  assign bus.feed_count = feed_cnt_q;
`else
  assign bus.feed_count = '0;
`endif

endmodule

// File: tb/tb_feed_sequencer.sv
// Directed bench for feed_sequencer: per-cycle vector tables plus hand-written corner sequences.
module tb_feed_sequencer;
  import feeder_pkg::*;

  localparam int unsigned D = 4, S = 2, C = 3, I = 20, MAXP = 4, PW = 3;
`ifdef FEED_COUNTER_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  typedef struct {
    bit man; bit inc; bit ab; bit ae;
    bit motor; bit busy; bit done; bit src;
    int fcnt; int sel;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  vec_t tv[100];

  feed_sequencer_if #(.PORTION_W(PW)) bus ();

  feed_sequencer #(
    .DISPENSE_CYCLES(D), .SETTLE_CYCLES(S), .COOLDOWN_CYCLES(C),
    .INTERVAL_CYCLES(I), .MAX_PORTIONS(MAXP), .PORTION_W(PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time=%0t want <200000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit m, input bit p, input bit ab, input bit ae);
    bus.manual_req  = m;
    bus.portion_inc = p;
    bus.abort       = ab;
    bus.auto_en     = ae;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic clear_tv(input int n, input bit ae);
    for (int k = 0; k < n; k++) begin
      tv[k].man = 0; tv[k].inc = 0; tv[k].ab = 0; tv[k].ae = ae;
      tv[k].motor = 0; tv[k].busy = 0; tv[k].done = 0; tv[k].src = 0;
      tv[k].fcnt = 0; tv[k].sel = 1;
    end
  endtask

  // One-portion feed whose first motor cycle is s: 4 on, 2 settle, 3 cooldown, done on cooldown entry.
  task automatic feed1(input int s, input bit srcv, input int n);
    for (int k = s; k < n; k++) begin
      if (k <= s + 3) tv[k].motor = 1;
      if (k <= s + 8) tv[k].busy = 1;
      if (k == s + 6) tv[k].done = 1;
      if (k >= s + 6) tv[k].fcnt += CNT_EN;
      tv[k].src = srcv;
    end
  endtask

  task automatic run_vectors(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_motor"}, int'(bus.motor_en), int'(tv[k].motor));
      chk({tag, "_busy"},  int'(bus.busy), int'(tv[k].busy));
      chk({tag, "_done"},  int'(bus.feed_done), int'(tv[k].done));
      chk({tag, "_src"},   int'(bus.last_src_manual), int'(tv[k].src));
      chk({tag, "_fcnt"},  int'(bus.feed_count), tv[k].fcnt);
      chk({tag, "_sel"},   int'(bus.portions_sel), tv[k].sel);
      drive(tv[k].man, tv[k].inc, tv[k].ab, tv[k].ae);
      step();
    end
  endtask

  initial begin
    // Single manual portion from reset.
    do_reset();
    clear_tv(25, 0);
    tv[10].man = 1;
    feed1(11, 1, 25);
    run_vectors("man1", 25);

    // Three portions; a selection change mid-feed waits for the next feed.
    drive(0, 1, 0, 0); step(); chk("inc_a", int'(bus.portions_sel), 2);
    drive(0, 1, 0, 0); step(); chk("inc_b", int'(bus.portions_sel), 3);
    drive(1, 0, 0, 0); step();
    for (int o = 1; o <= 22; o++) begin
      chk("p3_motor", int'(bus.motor_en),
          int'((o >= 1 && o <= 4) || (o >= 7 && o <= 10) || (o >= 13 && o <= 16)));
      chk("p3_done", int'(bus.feed_done), int'(o == 19));
      chk("p3_busy", int'(bus.busy), int'(o <= 21));
      chk("p3_sel", int'(bus.portions_sel), (o >= 4) ? 4 : 3);
      drive(0, o == 3, 0, 0);
      step();
    end
    chk("p3_fcnt", int'(bus.feed_count), 2 * CNT_EN);
    drive(0, 1, 0, 0); step(); chk("wrap_1", int'(bus.portions_sel), 1);
    drive(0, 1, 0, 0); step(); chk("wrap_2", int'(bus.portions_sel), 2);
    drive(0, 1, 0, 0); step(); chk("wrap_3", int'(bus.portions_sel), 3);
    drive(0, 0, 0, 0); step();

    // Auto feeds every 20 cycles; a press during DISPENSE is dropped.
    do_reset();
    clear_tv(66, 1);
    tv[23].man = 1;
    feed1(21, 0, 66);
    feed1(41, 0, 66);
    feed1(61, 0, 66);
    run_vectors("auto", 66);

    // Wrap in cooldown served at first IDLE cycle; press joins an auto start; wrap absorbed by a start.
    do_reset();
    clear_tv(81, 1);
    tv[12].man = 1;
    tv[40].man = 1;
    tv[59].man = 1;
    feed1(13, 1, 81);
    feed1(23, 0, 81);
    feed1(41, 1, 81);
    feed1(60, 1, 81);
    run_vectors("mix", 81);

    // Abort in 2nd motor cycle; press on last cooldown cycle; aborts in COOLDOWN/IDLE ignored.
    do_reset();
    clear_tv(25, 0);
    tv[5].man = 1; tv[10].man = 1;
    tv[7].ab = 1;  tv[19].ab = 1; tv[22].ab = 1;
    for (int k = 6; k < 25; k++) tv[k].src = 1;
    tv[6].motor = 1; tv[7].motor = 1;
    for (int k = 6; k <= 10; k++) tv[k].busy = 1;
    feed1(12, 1, 25);
    run_vectors("abort", 25);

    // Asynchronous reset between edges mid-DISPENSE.
    drive(0, 1, 0, 0); step(); chk("ar_sel_pre", int'(bus.portions_sel), 2);
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0); step();
    chk("ar_motor_pre", int'(bus.motor_en), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_motor", int'(bus.motor_en), 0);
    chk("ar_busy", int'(bus.busy), 0);
    chk("ar_sel", int'(bus.portions_sel), 1);
    chk("ar_fcnt", int'(bus.feed_count), 0);
    chk("ar_src", int'(bus.last_src_manual), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 12; k++) begin
      chk("ar_idle_busy", int'(bus.busy), 0);
      chk("ar_idle_motor", int'(bus.motor_en), 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feed_sequencer.md
Name: feed_sequencer

Overview:
Sequences the dispenser motor of the pet feeder from two request sources: manual one-cycle press pulses from the debounced feed button, and an internal periodic auto-feed timer. It arbitrates between the two, runs a multi-portion dispense/settle sequence and enforces a cooldown lockout. It sits between the button debouncers and the motor driver.

Parameters:
DISPENSE_CYCLES, 50, motor-on cycles per portion (>=1)
SETTLE_CYCLES, 20, motor-off gap after each portion (>=1)
COOLDOWN_CYCLES, 200, lockout cycles after a feed or abort (>=1)
INTERVAL_CYCLES, 1000, auto-feed period in clk cycles (>=2)
MAX_PORTIONS, 4, largest selectable portion count (1..2**PORTION_W-1)
PORTION_W, 3, width of the portion select register

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
manual_req  in  1  one-cycle pulse from the feed-button debouncer's press output
portion_inc  in  1  one-cycle pulse from the portion-button debouncer's press output
auto_en  in  1  level; enables the auto-feed timer
abort  in  1  one-cycle pulse; jam or stop request
motor_en  out  1  registered motor drive
busy  out  1  high whenever state != IDLE
feed_done  out  1  one-cycle pulse when a feed completes normally
last_src_manual  out  1  source of the most recent started feed: 1 = manual, 0 = auto
portions_sel  out  PORTION_W  portions per feed currently selected
feed_count  out  8  completed feeds; see Optional Feature

Behaviour:
- Reset values (async, rst_n=0): state IDLE; all outputs 0 except portions_sel=1; interval counter 0; man_pend, auto_pend 0.
- FSM states: IDLE, DISPENSE, SETTLE, COOLDOWN. All outputs registered.
- portion_inc: accepted in any state. Increments portions_sel; MAX_PORTIONS wraps to 1. At feed start portions_sel is latched into remaining = portions_sel. A change takes effect on the next feed only.
- Auto timer with auto_en=1: counter increments every cycle. At INTERVAL_CYCLES-1, the counter returns to 0 and auto_pend is set.
- Auto timer with auto_en=0: counter and auto_pend are held at 0.
- manual_req while in IDLE: starts a feed.
- manual_req outside IDLE: dropped, no queuing. man_pend exists only to capture manual_req coincident with the IDLE entry cycle.
- auto_pend raised outside IDLE: held, and served after cooldown.
- IDLE -> DISPENSE when manual_req | man_pend | auto_pend.
  - Manual wins: last_src_manual=1 if manual_req|man_pend, else 0.
  - Both pend flags clear on start; one feed satisfies both sources.
  - Latency: request sampled in cycle N, motor_en=1 from N+1.
- DISPENSE: motor_en=1 for exactly DISPENSE_CYCLES cycles, then SETTLE.
- SETTLE: motor_en=0 for SETTLE_CYCLES cycles.
  - If remaining>1: decrement remaining, go to DISPENSE.
  - Else: go to COOLDOWN, with feed_done=1 for the first COOLDOWN cycle.
- COOLDOWN: COOLDOWN_CYCLES cycles, then IDLE. A pending auto_pend starts the next feed in the first IDLE cycle.
- abort in DISPENSE or SETTLE: motor_en=0 next cycle, go to COOLDOWN, no feed_done, auto_pend cleared.
- abort in IDLE or COOLDOWN: ignored.
- Same-cycle events:
  - abort has priority over a phase-count expiry.
  - A timer wrap coincident with a start is absorbed into that start.
- Phase counter: a single counter sized $clog2 of the largest phase length. It is reloaded on every state entry.

Optional Feature:
Macro FEED_COUNTER_EN.
- Defined: feed_count increments on each feed_done and saturates at 255. Abort does not count. It resets to 0.
- Undefined: feed_count is tied to 0 and no counter is synthesised.

Decomposition:
- Shared package feeder_pkg:
  - state enum (IDLE/DISPENSE/SETTLE/COOLDOWN)
  - source encoding constants (SRC_AUTO=0, SRC_MANUAL=1)
  - feed_count width constant (8)
- One natural sub-module, feed_interval_timer: auto_en in, one-cycle wrap pulse out, parameter INTERVAL_CYCLES.

Test Plan (DISPENSE=4, SETTLE=2, COOLDOWN=3, INTERVAL=20, MAX=4, PORTION_W=3):
1. manual_req at cycle 10 with portions_sel=1, auto_en=0 -> motor_en high cycles 11-14; feed_done at 17; busy low from 20; last_src_manual=1; feed_count=1.
2. portion_inc x2 then manual_req -> portions_sel=3; three 4-cycle motor bursts separated by 2-cycle gaps; one feed_done; 4 further portion_inc pulses wrap the sequence to 4, 1, 2, 3.
3. auto_en=1 from reset -> feeds start at cycles 20, 40, 60 with last_src_manual=0. A manual_req during DISPENSE is dropped, giving no extra feed.
4. abort in 2nd motor cycle -> motor_en=0 next cycle; COOLDOWN 3 cycles; no feed_done; feed_count unchanged.
5. Timer wrap during COOLDOWN -> new feed starts in the first IDLE cycle. manual_req coincident with an auto start -> single feed, last_src_manual=1.
6. rst_n low mid-DISPENSE (async, between edges) -> motor_en=0 immediately; portions_sel=1, feed_count=0. After release, the sequencer idles until the next request.
